// File: rtl/gate3_pkg.sv
// Shared opcode encoding and width-generic evaluation helpers for gate3_pipe.
// Helpers work on MAX_W-bit vectors; callers zero-extend narrower operands.
package gate3_pkg;

   localparam int OP_W  = 3;
   localparam int MAX_W = 64;
   localparam int POP_W = $clog2(MAX_W + 1);

   typedef enum logic [OP_W-1:0] {
      OP_AND3  = 3'd0,
      OP_OR3   = 3'd1,
      OP_XOR3  = 3'd2,
      OP_NAND3 = 3'd3,
      OP_NOR3  = 3'd4,
      OP_XNOR3 = 3'd5,
      OP_MAJ   = 3'd6,
      OP_MUX   = 3'd7
   } op_e;

   function automatic logic [MAX_W-1:0] gate3_eval(input op_e op,
                                                   input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input logic [MAX_W-1:0] c);
      logic [MAX_W-1:0] r;
      case (op)
         OP_AND3:  r = a & b & c;
         OP_OR3:   r = a | b | c;
         OP_XOR3:  r = a ^ b ^ c;
         OP_NAND3: r = ~(a & b & c);
         OP_NOR3:  r = ~(a | b | c);
         OP_XNOR3: r = ~(a ^ b ^ c);
         OP_MAJ:   r = (a & b) | (a & c) | (b & c);
         OP_MUX:   r = (c & b) | (~c & a);
         default:  r = {MAX_W{1'b0}};
      endcase
      return r;
   endfunction

   function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
      logic [POP_W-1:0] n;
      n = {POP_W{1'b0}};
      for (int i = 0; i < MAX_W; i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gate3_fifo2.sv
// Two-entry in-order synchronous FIFO with cleared storage on reset.
// The head output reads as zero whenever the FIFO is empty.
module gate3_fifo2 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic [1:0]    o_cnt
);

   logic [DW-1:0] r_mem [2];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_cnt;
   logic          w_do_push;
   logic          w_do_pop;

   // Overflow and underflow requests are ignored rather than corrupting state.
   assign w_do_push = i_push && (r_cnt != 2'd2);
   assign w_do_pop  = i_pop  && (r_cnt != 2'd0);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= {DW{1'b0}};
         r_mem[1] <= {DW{1'b0}};
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Head entry, masked so stale popped data never shows on an empty FIFO.
   always_comb begin
      o_data = {DW{1'b0}};
      if (r_cnt != 2'd0) begin
         o_data = r_mem[r_rd_ptr];
      end else begin
         o_data = {DW{1'b0}};
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/gate3_pipe.sv
// Back-pressurable 3-input bitwise function unit: evaluates on accept, buffers
// results two deep, and counts delivered results.
module gate3_pipe
   import gate3_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [OP_W-1:0]              in_op,
   input  logic [WIDTH-1:0]             in_a,
   input  logic [WIDTH-1:0]             in_b,
   input  logic [WIDTH-1:0]             in_c,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_y,
   output logic [OP_W-1:0]              out_op,
   output logic [$clog2(WIDTH+1)-1:0]   out_ones,
   output logic [CNT_W-1:0]             txn_count
);

   localparam int ONES_W = $clog2(WIDTH + 1);
   localparam int DW     = OP_W + ONES_W + WIDTH;

   logic [MAX_W-1:0]  w_eval;
   logic [WIDTH-1:0]  w_y;
   logic [POP_W-1:0]  w_pop_full;
   logic [ONES_W-1:0] w_ones;
   logic [DW-1:0]     w_head;
   logic [1:0]        w_cnt;
   logic              w_push;
   logic              w_pop;
   logic              w_unused;
   logic [CNT_W-1:0]  r_txn;

   // Helpers are evaluated at full width; only the low WIDTH bits are meaningful.
   assign w_eval     = gate3_eval(op_e'(in_op), MAX_W'(in_a), MAX_W'(in_b), MAX_W'(in_c));
   assign w_y        = w_eval[WIDTH-1:0];
   assign w_pop_full = popcount(MAX_W'(w_y));
   assign w_ones     = w_pop_full[ONES_W-1:0];
   assign w_unused   = ^{w_eval, w_pop_full};

   assign in_ready  = !rst && (w_cnt != 2'd2);
   assign out_valid = (w_cnt != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   gate3_fifo2 #(.DW(DW)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push),
      .i_pop  (w_pop),
      .i_data ({in_op, w_ones, w_y}),
      .o_data (w_head),
      .o_cnt  (w_cnt)
   );

   assign out_op   = w_head[DW-1 -: OP_W];
   assign out_ones = w_head[WIDTH +: ONES_W];
   assign out_y    = w_head[WIDTH-1:0];

   // Delivered-result counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_txn <= {CNT_W{1'b0}};
      end else if (w_pop) begin
         r_txn <= r_txn + CNT_W'(1'b1);
      end
   end

   assign txn_count = r_txn;

endmodule

// File: tb/tb_gate3_pipe.sv
// Directed and scoreboarded bench for gate3_pipe; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_gate3_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [2:0]  in_op;
   logic [7:0]  in_a, in_b, in_c;
   logic        out_ready;

   logic        in_ready, out_valid;
   logic [7:0]  out_y;
   logic [2:0]  out_op;
   logic [3:0]  out_ones;
   logic [15:0] txn_count;

   logic        in_ready4, out_valid4;
   logic [7:0]  out_y4;
   logic [2:0]  out_op4;
   logic [3:0]  out_ones4;
   logic [3:0]  txn_count4;

   int n_checks = 0;
   int n_errors = 0;
   int exp_txn  = 0;

   logic [7:0] exp_y    [8] = '{8'h80, 8'hFE, 8'h96, 8'h7F, 8'h01, 8'h69, 8'hE8, 8'hD8};
   logic [3:0] exp_ones [8] = '{4'd1, 4'd7, 4'd4, 4'd7, 4'd1, 4'd4, 4'd4, 4'd4};
   logic [14:0] sb_q [$];

   always #5 clk = ~clk;

   gate3_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_op(out_op), .out_ones(out_ones), .txn_count(txn_count)
   );

   gate3_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid4), .out_ready(out_ready),
      .out_y(out_y4), .out_op(out_op4), .out_ones(out_ones4), .txn_count(txn_count4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
      case (op)
         3'd0:    return a & b & c;
         3'd1:    return a | b | c;
         3'd2:    return a ^ b ^ c;
         3'd3:    return ~(a & b & c);
         3'd4:    return ~(a | b | c);
         3'd5:    return ~(a ^ b ^ c);
         3'd6:    return (a & b) | (a & c) | (b & c);
         default: begin
            logic [7:0] r;
            for (int i = 0; i < 8; i++) r[i] = c[i] ? b[i] : a[i];
            return r;
         end
      endcase
   endfunction

   task automatic check_head(input string tag, input logic [2:0] op, input logic [7:0] y,
                             input logic [3:0] ones);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_y"},     {24'd0, out_y},     {24'd0, y});
      check({tag, "_op"},    {29'd0, out_op},    {29'd0, op});
      check({tag, "_ones"},  {28'd0, out_ones},  {28'd0, ones});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; out_ready = 1'b0;
      in_a = 8'hF0; in_b = 8'hCC; in_c = 8'hAA;

      // 1: reset, then a single AND3 transaction
      step(); step();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      #1;
      check("t1_pre_valid", {31'd0, out_valid}, 32'd0);
      check("t1_pre_ready", {31'd0, in_ready}, 32'd1);
      check("t1_pre_txn", {16'd0, txn_count}, 32'd0);
      in_valid = 1'b1; in_op = 3'd0; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_head("t1", 3'd0, 8'h80, 4'd1);
      step();
      exp_txn = 1;
      check("t1_txn", {16'd0, txn_count}, 32'd1);
      check("t1_post_valid", {31'd0, out_valid}, 32'd0);

      // 2: sweep all opcodes back-to-back
      in_valid = 1'b1; in_op = 3'd0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i < 7) in_op = 3'(i + 1);
         else in_valid = 1'b0;
         check_head($sformatf("t2_op%0d", i), 3'(i), exp_y[i], exp_ones[i]);
         check($sformatf("t2_ready%0d", i), {31'd0, in_ready}, 32'd1);
      end
      step();
      exp_txn += 8;
      check("t2_txn", {16'd0, txn_count}, 32'(exp_txn));
      check("t2_empty", {31'd0, out_valid}, 32'd0);

      // 3: back-pressure fills the buffer, then drains in order
      out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd1;
      step();
      check("t3_ready1", {31'd0, in_ready}, 32'd1);
      check("t3_y1", {24'd0, out_y}, 32'hFE);
      in_op = 3'd2;
      step();
      check("t3_full_ready", {31'd0, in_ready}, 32'd0);
      check("t3_y2", {24'd0, out_y}, 32'hFE);
      in_op = 3'd3;
      step();
      check("t3_stall_y", {24'd0, out_y}, 32'hFE);
      check("t3_stall_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      exp_txn++;
      check_head("t3_d2", 3'd2, 8'h96, 4'd4);
      check("t3_ready_freed", {31'd0, in_ready}, 32'd1);
      step();
      exp_txn++;
      in_valid = 1'b0;
      check_head("t3_d3", 3'd3, 8'h7F, 4'd7);
      step();
      exp_txn++;
      check("t3_empty", {31'd0, out_valid}, 32'd0);
      check("t3_txn", {16'd0, txn_count}, 32'(exp_txn));

      // 4: random traffic against a scoreboard
      sb_q.delete();
      for (int i = 0; i < 1004; i++) begin
         logic do_push, do_pop;
         if (i < 1000) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 50);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         in_op = 3'($urandom_range(0, 7));
         in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom);
         check("t4_ready", {31'd0, in_ready}, {31'd0, (sb_q.size() < 2)});
         check("t4_valid", {31'd0, out_valid}, {31'd0, (sb_q.size() != 0)});
         if (sb_q.size() != 0) begin
            check("t4_head", {17'd0, out_op, out_ones, out_y}, {17'd0, sb_q[0]});
         end
         check("t4_txn", {16'd0, txn_count}, exp_txn & 32'hFFFF);
         do_pop  = (sb_q.size() != 0) && out_ready;
         do_push = in_valid && (sb_q.size() < 2);
         if (do_push) begin
            logic [7:0] y;
            y = ref_y(in_op, in_a, in_b, in_c);
            sb_q.push_back({in_op, 4'($countones(y)), y});
         end
         step();
         if (do_pop) begin
            void'(sb_q.pop_front());
            exp_txn++;
         end
      end
      check("t4_drained", {31'd0, out_valid}, 32'd0);

      // 5: reset with a full buffer
      in_a = 8'hF0; in_b = 8'hCC; in_c = 8'hAA;
      out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd1;
      step();
      in_op = 3'd2;
      step();
      check("t5_full", {31'd0, in_ready}, 32'd0);
      rst = 1'b1; in_op = 3'd4;
      #1;
      check("t5_rst_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
      check("t5_rst_y", {24'd0, out_y}, 32'd0);
      check("t5_rst_op", {29'd0, out_op}, 32'd0);
      check("t5_rst_ones", {28'd0, out_ones}, 32'd0);
      check("t5_rst_txn", {16'd0, txn_count}, 32'd0);
      check("t5_rst_ready_hi", {31'd0, in_ready}, 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("t5_post_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("t5_post_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1; in_op = 3'd6; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_head("t5_new", 3'd6, 8'hE8, 4'd4);
      step();
      check("t5_empty", {31'd0, out_valid}, 32'd0);
      check("t5_txn", {16'd0, txn_count}, 32'd1);

      // 6: 17 handshakes after reset; the 4-bit counter wraps to 1
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_op = 3'd2;
      for (int i = 0; i < 17; i++) step();
      in_valid = 1'b0;
      step();
      check("t6_txn16", {16'd0, txn_count}, 32'd17);
      check("t6_txn4", {28'd0, txn_count4}, 32'd1);
      check("t6_empty4", {31'd0, out_valid4}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
